fb_wr_arbiter: RTL and testbench

Shares the single framebuffer write port (fb_wr_valid/ready/addr/data into the AXI framebuffer master) between NUM_REQ write requesters, e.g. clear engine (idx 0) and fragment writer (idx 1).
Round-robin grant, held for up to HOLD_BEATS beats so requester address streams stay contiguous for the master's bursts.
Registered output stage; sits between the gpu_core write sources and the AXI framebuffer master.

---
 rtl/fb_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fb_wr_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_wr_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between NUM_REQ requesters,
// holding each grant for up to HOLD_BEATS beats. Optional per-requester beat counters: FB_WR_ARB_STATS_EN.
module fb_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int HOLD_BEATS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          fb_wr_valid,
    input  logic                          fb_wr_ready,
    output logic [ADDR_WIDTH-1:0]         fb_wr_addr,
    output logic [DATA_WIDTH-1:0]         fb_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef FB_WR_ARB_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*32-1:0]         stat_beats
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HOLD_BEATS - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   slot_free;
    logic                   hs;
    logic                   release_grant;
    logic                   pick_any;
    logic [ID_W-1:0]        pick_idx;
    logic [ID_W-1:0]        next_ptr;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;

    assign slot_free     = !fb_wr_valid || fb_wr_ready;
    assign hs            = (state == GRANT) && req_valid[grant_id] && slot_free;
    assign release_grant = !req_valid[grant_id] || (hs && beat_cnt == LAST_BEAT);
    assign next_ptr      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign busy          = (state == GRANT) || fb_wr_valid;

    // req_ready must follow fb_wr_ready in the same cycle so the output slot is
    // refilled while it drains; a registered ready would cost a bubble per beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_ready = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = slot_free;
        end
    end

    // Lowest offset from rr_ptr wins: scanning offsets downwards lets it overwrite the others.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                pick_any = 1'b1;
                pick_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            grant_id    <= '0;
            fb_wr_valid <= 1'b0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
        end else begin
            if (hs) begin
                fb_wr_valid <= 1'b1;
                fb_wr_addr  <= sel_addr;
                fb_wr_data  <= sel_data;
            end else if (fb_wr_ready) begin
                fb_wr_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_WR_ARB_STATS_EN
    logic [31:0] stat_cnt [NUM_REQ];

    // stat_clr wins over a same-cycle increment; counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (hs) begin
            stat_cnt[grant_id] <= stat_cnt[grant_id] + 32'd1;
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_beats[i*32 +: 32] = stat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Bench for fb_wr_arbiter: table of arbitration vectors plus streaming scenarios
// scored through an expected-beat queue filled at requester handshakes.
module tb_fb_wr_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int HB = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              fb_wr_valid;
    logic              fb_wr_ready;
    logic [AW-1:0]     fb_wr_addr;
    logic [DW-1:0]     fb_wr_data;
    logic              grant_id;
    logic              busy;
`ifdef FB_WR_ARB_STATS_EN
    logic              stat_clr;
    logic [NR*32-1:0]  stat_beats;
`endif

    fb_wr_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .HOLD_BEATS (HB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef FB_WR_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_beats  (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_ready;
        logic          exp_gid;
        logic          exp_busy;
    } arb_vec_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            rem[NR];
    int            seq[NR];
    int            fb_beats = 0;
    int            last_lat = 0;
    int            last_hs_cyc = -100;
    logic [NR-1:0] hs_mask;
    int            run_len[32];
    int            run_id[32];
    int            run_gap[32];
    int            run_n;
    bit            run_open;
    int            cur_len;
    int            cur_id;
    int            cur_gap;

    function automatic logic [AW-1:0] addr_of(input int i, input int k);
        logic [AW-1:0] base;
        base = (i == 0) ? 32'h0000_2000 : 32'h0000_1000;
        return base + AW'(4 * k);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i, input int k);
        return {8'(i), 8'hD0, 16'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_runs();
        run_n       = 0;
        run_open    = 1'b0;
        last_hs_cyc = -100;
        for (int k = 0; k < 32; k++) begin
            run_len[k] = -1;
            run_id[k]  = -1;
            run_gap[k] = -1;
        end
    endtask

    task automatic close_run();
        if (run_open && run_n < 32) begin
            run_len[run_n] = cur_len;
            run_id[run_n]  = cur_id;
            run_gap[run_n] = cur_gap;
            run_n++;
        end
        run_open = 1'b0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = rem[i] > 0;
            req_addr[i*AW +: AW]  = addr_of(i, seq[i]);
            req_data[i*DW +: DW]  = data_of(i, seq[i]);
        end
    endtask

    task automatic observe();
        beat_t b;
        hs_mask = '0;
        if (!rst) begin
            check("one_ready", 64'($countones(req_ready) <= 1), 64'(1));
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_mask[i] = 1'b1;
                    exp_q.push_back('{addr_of(i, seq[i]), data_of(i, seq[i]), cyc});
                    check("hs_grant_id", 64'(grant_id), 64'(i));
                    if (run_open && cur_id == i && last_hs_cyc == cyc - 1) begin
                        cur_len++;
                    end else begin
                        close_run();
                        run_open = 1'b1;
                        cur_id   = i;
                        cur_len  = 1;
                        cur_gap  = cyc - last_hs_cyc - 1;
                    end
                    last_hs_cyc = cyc;
                end
            end
            if (fb_wr_valid && fb_wr_ready) begin
                fb_beats++;
                check("fb_beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("fb_addr", 64'(fb_wr_addr), 64'(b.addr));
                    check("fb_data", 64'(fb_wr_data), 64'(b.data));
                    last_lat = cyc - b.cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_mask[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive_reqs();
        fb_wr_ready = 1'b1;
`ifdef FB_WR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        fb_beats = 0;
        hs_mask  = '0;
        clear_runs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((rem[0] > 0 || rem[1] > 0 || exp_q.size() > 0 || fb_wr_valid) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain_in_budget"}, 64'(n < budget), 64'(1));
        close_run();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        arb_vec_t vecs[4];
        int       n;

        vecs[0] = '{mask: 2'b00, exp_ready: 2'b00, exp_gid: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{mask: 2'b01, exp_ready: 2'b01, exp_gid: 1'b0, exp_busy: 1'b1};
        vecs[2] = '{mask: 2'b10, exp_ready: 2'b10, exp_gid: 1'b1, exp_busy: 1'b1};
        vecs[3] = '{mask: 2'b11, exp_ready: 2'b01, exp_gid: 1'b0, exp_busy: 1'b1};

        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        fb_wr_ready = 1'b0;
        rst         = 1'b1;
`ifdef FB_WR_ARB_STATS_EN
        stat_clr    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_fb_valid", 64'(fb_wr_valid), 64'(0));
        check("rst_fb_addr",  64'(fb_wr_addr),  64'(0));
        check("rst_fb_data",  64'(fb_wr_data),  64'(0));
        check("rst_req_ready", 64'(req_ready),  64'(0));
        check("rst_busy",     64'(busy),        64'(0));
        check("rst_grant_id", 64'(grant_id),    64'(0));

        // Arbitration from a fresh reset: one IDLE cycle, then the lowest valid index wins.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < NR; i++) rem[i] = vecs[v].mask[i] ? 4 : 0;
            drive_reqs();
            #1;
            check("arb_idle_ready", 64'(req_ready), 64'(0));
            step();
            #1;
            check("arb_grant_id", 64'(grant_id),  64'(vecs[v].exp_gid));
            check("arb_ready",    64'(req_ready), 64'(vecs[v].exp_ready));
            check("arb_busy",     64'(busy),      64'(vecs[v].exp_busy));
        end

        // Single requester, 40 beats: grants split 16/16/8 with one IDLE bubble between.
        do_reset();
        rem[1] = 40;
        drive_reqs();
        drain("s1", 200);
        check("s1_fb_beats", 64'(fb_beats), 64'(40));
        check("s1_runs",     64'(run_n),    64'(3));
        check("s1_len0", 64'(run_len[0]), 64'(16));
        check("s1_len1", 64'(run_len[1]), 64'(16));
        check("s1_len2", 64'(run_len[2]), 64'(8));
        check("s1_id2",  64'(run_id[2]),  64'(1));
        check("s1_gap1", 64'(run_gap[1]), 64'(1));
        check("s1_gap2", 64'(run_gap[2]), 64'(1));
        check("s1_last_latency", 64'(last_lat), 64'(1));
        #1;
        check("s1_idle_busy", 64'(busy), 64'(0));

        // Contention: both requesters valid throughout; 16-beat grants alternate 0,1,0,1.
        do_reset();
        rem[0] = 32;
        rem[1] = 32;
        drive_reqs();
        drain("s2", 300);
        check("s2_fb_beats", 64'(fb_beats), 64'(64));
        check("s2_runs",     64'(run_n),    64'(4));
        for (int k = 0; k < 4; k++) begin
            check("s2_run_id",  64'(run_id[k]),  64'(k % 2));
            check("s2_run_len", 64'(run_len[k]), 64'(16));
        end
`ifdef FB_WR_ARB_STATS_EN
        #1;
        check("s6_stat_req0", 64'(stat_beats[31:0]),  64'(32));
        check("s6_stat_req1", 64'(stat_beats[63:32]), 64'(32));
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check("s6_stat_cleared", 64'(stat_beats), 64'(0));
`endif

        // Backpressure: 5 stall cycles while the 3rd beat is on fb_wr.
        do_reset();
        rem[0] = 20;
        drive_reqs();
        n = 0;
        while (!(fb_wr_valid && fb_wr_addr == addr_of(0, 2)) && n < 20) begin
            step();
            n++;
        end
        check("s3_third_beat_seen", 64'(n < 20), 64'(1));
        fb_wr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("s3_hold_valid", 64'(fb_wr_valid), 64'(1));
            check("s3_hold_addr",  64'(fb_wr_addr),  64'(addr_of(0, 2)));
            check("s3_hold_data",  64'(fb_wr_data),  64'(data_of(0, 2)));
            if (s >= 1) check("s3_ready_low", 64'(req_ready), 64'(0));
            step();
        end
        fb_wr_ready = 1'b1;
        drain("s3", 100);
        check("s3_fb_beats", 64'(fb_beats), 64'(20));
        check("s3_runs",  64'(run_n),      64'(3));
        check("s3_len0",  64'(run_len[0]), 64'(3));
        check("s3_len1",  64'(run_len[1]), 64'(13));
        check("s3_gap1",  64'(run_gap[1]), 64'(5));
        check("s3_len2",  64'(run_len[2]), 64'(4));
        check("s3_gap2",  64'(run_gap[2]), 64'(1));

        // Early release: req0 stops after 3 beats; req1 takes over, then rr_ptr returns to 0.
        do_reset();
        rem[0] = 3;
        rem[1] = 5;
        drive_reqs();
        drain("s4a", 100);
        rem[0] = 2;
        rem[1] = 2;
        drive_reqs();
        drain("s4b", 100);
        check("s4_runs", 64'(run_n), 64'(4));
        check("s4_id0",  64'(run_id[0]),  64'(0));
        check("s4_len0", 64'(run_len[0]), 64'(3));
        check("s4_id1",  64'(run_id[1]),  64'(1));
        check("s4_len1", 64'(run_len[1]), 64'(5));
        // valid-drop cycle plus the IDLE arbitration cycle
        check("s4_gap1", 64'(run_gap[1]), 64'(2));
        check("s4_id2",  64'(run_id[2]),  64'(0));
        check("s4_id3",  64'(run_id[3]),  64'(1));

        // Reset while a beat is held under backpressure.
        do_reset();
        rem[1] = 10;
        drive_reqs();
        n = 0;
        while (!fb_wr_valid && n < 20) begin
            step();
            n++;
        end
        check("s5_beat_seen", 64'(n < 20), 64'(1));
        fb_wr_ready = 1'b0;
        #1;
        check("s5_pre_busy",  64'(busy),     64'(1));
        check("s5_pre_grant", 64'(grant_id), 64'(1));
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive_reqs();
        @(posedge clk);
        #1;
        check("s5_fb_valid",  64'(fb_wr_valid), 64'(0));
        check("s5_req_ready", 64'(req_ready),   64'(0));
        check("s5_busy",      64'(busy),        64'(0));
        check("s5_grant_id",  64'(grant_id),    64'(0));
        rst         = 1'b0;
        fb_wr_ready = 1'b1;
        exp_q.delete();
        fb_beats = 0;
        hs_mask  = '0;
        clear_runs();
        rem[0] = 2;
        rem[1] = 2;
        drive_reqs();
        drain("s5", 100);
        check("s5_first_id", 64'(run_id[0]), 64'(0));
        check("s5_fb_beats", 64'(fb_beats),  64'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
